// File: rtl/gaussian_pkg.sv
// Constants shared by the binomial Gaussian filter: kernel rows, normalising shift
// and centre tap index.
package gaussian_pkg;

   localparam int unsigned Binom3 [3] = '{1, 2, 1};
   localparam int unsigned Binom5 [5] = '{1, 4, 6, 4, 1};

   function automatic int unsigned coef(input int unsigned ksize, input int unsigned idx);
      if (ksize == 5) begin
         return Binom5[idx];
      end
      return Binom3[idx];
   endfunction

   // log2 of the kernel weight sum (16 for 3x3, 256 for 5x5)
   function automatic int unsigned shift_for(input int unsigned ksize);
      return (ksize == 5) ? 8 : 4;
   endfunction

   function automatic int unsigned centre_of(input int unsigned ksize);
      return ksize / 2;
   endfunction

endpackage

// File: rtl/gaussian_col_sum.sv
// Combinational vertical weighted sum of one window column using the binomial row.
module gaussian_col_sum
   import gaussian_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned KSIZE = 3,
   parameter int unsigned SUMW  = WIDTH + shift_for(KSIZE) / 2
) (
   input  logic [KSIZE*WIDTH-1:0] col_i,
   output logic [SUMW-1:0]        sum_o
);

   always_comb begin
      sum_o = '0;
      for (int r = 0; r < KSIZE; r++) begin
         sum_o = sum_o + SUMW'(coef(KSIZE, r)) * SUMW'(col_i[r*WIDTH +: WIDTH]);
      end
   end

endmodule

// File: rtl/gaussian_conv.sv
// Three-stage binomial Gaussian filter (3x3 or 5x5) with rounding, per-sample bypass,
// global-stall valid/ready handshake and a sticky dropped-input flag.
module gaussian_conv
   import gaussian_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned KSIZE = 3
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic [KSIZE*KSIZE*WIDTH-1:0] window_in,
   input  logic                     bypass_in,
   input  logic                     data_valid_in,
   output logic                     data_ready_out,
   output logic [WIDTH-1:0]         data_out,
   output logic                     data_valid_out,
   input  logic                     data_ready_in,
   output logic                     error_out,
   output logic                     busy_out
);

   localparam int unsigned Shift  = shift_for(KSIZE);
   localparam int unsigned ColW   = WIDTH + Shift / 2;
   localparam int unsigned SumW   = WIDTH + Shift;
   localparam int unsigned Ctr    = centre_of(KSIZE);
   localparam int unsigned CtrBit = (Ctr * KSIZE + Ctr) * WIDTH;
   localparam logic [SumW:0] RoundC = (SumW + 1)'(2 ** (Shift - 1));

   if (!(KSIZE == 3 || KSIZE == 5)) begin : g_ksize_check
      $error("gaussian_conv: KSIZE must be 3 or 5");
   end

   logic [KSIZE*WIDTH-1:0] col     [KSIZE];
   logic [ColW-1:0]        col_sum [KSIZE];

   logic [ColW-1:0]  s1_sum_q [KSIZE];
   logic [ColW-1:0]  s1_sum_d [KSIZE];
   logic             s1_valid_q, s1_valid_d, s1_byp_q, s1_byp_d;
   logic [WIDTH-1:0] s1_ctr_q, s1_ctr_d;
   logic [SumW-1:0]  s2_sum_q, s2_sum_d;
   logic             s2_valid_q, s2_valid_d, s2_byp_q, s2_byp_d;
   logic [WIDTH-1:0] s2_ctr_q, s2_ctr_d;
   logic [WIDTH-1:0] s3_data_q, s3_data_d;
   logic             s3_valid_q, s3_valid_d;
   logic             error_q, error_d;
   logic             advance;

   // Regroup the row-major window into per-column vectors for the column adders
   always_comb begin
      for (int c = 0; c < KSIZE; c++) begin
         for (int r = 0; r < KSIZE; r++) begin
            col[c][r*WIDTH +: WIDTH] = window_in[(r*KSIZE + c)*WIDTH +: WIDTH];
         end
      end
   end

   for (genvar c = 0; c < KSIZE; c++) begin : g_col
      gaussian_col_sum #(
         .WIDTH(WIDTH),
         .KSIZE(KSIZE),
         .SUMW (ColW)
      ) u_col_sum (
         .col_i(col[c]),
         .sum_o(col_sum[c])
      );
   end

   assign advance = ~s3_valid_q | data_ready_in;

   always_comb begin
      s1_sum_d   = col_sum;
      s1_valid_d = data_valid_in;
      s1_byp_d   = bypass_in;
      s1_ctr_d   = window_in[CtrBit +: WIDTH];

      s2_sum_d = '0;
      for (int c = 0; c < KSIZE; c++) begin
         s2_sum_d = s2_sum_d + SumW'(coef(KSIZE, c)) * SumW'(s1_sum_q[c]);
      end
      s2_valid_d = s1_valid_q;
      s2_byp_d   = s1_byp_q;
      s2_ctr_d   = s1_ctr_q;

      // Max rounded result is exactly 2^WIDTH-1, so dropping the high bits is lossless
      s3_data_d  = s2_byp_q ? s2_ctr_q : WIDTH'(({1'b0, s2_sum_q} + RoundC) >> Shift);
      s3_valid_d = s2_valid_q;

      error_d = error_q | (data_valid_in & ~advance);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         s1_sum_q   <= '{default: '0};
         s1_valid_q <= 1'b0;
         s1_byp_q   <= 1'b0;
         s1_ctr_q   <= '0;
         s2_sum_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_byp_q   <= 1'b0;
         s2_ctr_q   <= '0;
         s3_data_q  <= '0;
         s3_valid_q <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         error_q <= error_d;
         if (advance) begin
            s1_sum_q   <= s1_sum_d;
            s1_valid_q <= s1_valid_d;
            s1_byp_q   <= s1_byp_d;
            s1_ctr_q   <= s1_ctr_d;
            s2_sum_q   <= s2_sum_d;
            s2_valid_q <= s2_valid_d;
            s2_byp_q   <= s2_byp_d;
            s2_ctr_q   <= s2_ctr_d;
            s3_data_q  <= s3_data_d;
            s3_valid_q <= s3_valid_d;
         end
      end
   end

   assign data_ready_out = advance;
   assign data_out       = s3_data_q;
   assign data_valid_out = s3_valid_q;
   assign error_out      = error_q;
   assign busy_out       = s1_valid_q | s2_valid_q | s3_valid_q;

endmodule

// File: tb/tb_gaussian_conv.sv
// Bench for gaussian_conv: one 3x3 and one 5x5 instance driven in lockstep and
// compared with a binomial-coefficient reference model.
module tb_gaussian_conv;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst, byp, vin, rdy_in;
   logic [9*W-1:0]  win3;
   logic [25*W-1:0] win5;
   logic           ready3, vout3, err3, busy3;
   logic           ready5, vout5, err5, busy5;
   logic [W-1:0]   dout3, dout5;

   int vectors = 0;
   int miscompares = 0;
   int unsigned got3[$], got5[$], exp3[$], exp5[$];

   gaussian_conv #(.WIDTH(W), .KSIZE(3)) dut3 (
      .clk_in(clk), .rst_in(rst), .window_in(win3), .bypass_in(byp),
      .data_valid_in(vin), .data_ready_out(ready3), .data_out(dout3),
      .data_valid_out(vout3), .data_ready_in(rdy_in), .error_out(err3), .busy_out(busy3)
   );

   gaussian_conv #(.WIDTH(W), .KSIZE(5)) dut5 (
      .clk_in(clk), .rst_in(rst), .window_in(win5), .bypass_in(byp),
      .data_valid_in(vin), .data_ready_out(ready5), .data_out(dout5),
      .data_valid_out(vout5), .data_ready_in(rdy_in), .error_out(err5), .busy_out(busy5)
   );

   always #5 clk = ~clk;

   // Records every completed output handshake
   always @(posedge clk) begin
      if (!rst) begin
         if (vout3 && rdy_in) got3.push_back(dout3);
         if (vout5 && rdy_in) got5.push_back(dout5);
      end
   end

   function automatic int unsigned choose(input int n, input int k);
      int unsigned res = 1;
      for (int i = 1; i <= k; i++) res = res * (n - k + i) / i;
      return res;
   endfunction

   // Weight (r,c) = C(k-1,r)*C(k-1,c); divide by total weight with round-half-up
   function automatic int unsigned model(input logic [25*W-1:0] w, input int k, input bit b);
      int unsigned sum = 0;
      int unsigned den = 0;
      int ctr = k / 2;
      if (b) return w[(ctr*k + ctr)*W +: W];
      for (int r = 0; r < k; r++)
         for (int c = 0; c < k; c++)
            sum += choose(k-1, r) * choose(k-1, c) * w[(r*k + c)*W +: W];
      for (int r = 0; r < k; r++)
         for (int c = 0; c < k; c++)
            den += choose(k-1, r) * choose(k-1, c);
      return (sum + den / 2) / den;
   endfunction

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Drives one sample to both instances and queues its expected results
   task automatic rand_load(input int lo, input int hi, input int centre, input bit b);
      logic [25*W-1:0] w5;
      logic [9*W-1:0]  w3;
      for (int i = 0; i < 25; i++) w5[i*W +: W] = W'($urandom_range(hi, lo));
      for (int i = 0; i < 9; i++)  w3[i*W +: W] = W'($urandom_range(hi, lo));
      if (centre >= 0) begin
         w5[12*W +: W] = W'(centre);
         w3[4*W +: W]  = W'(centre);
      end
      win3 = w3; win5 = w5; byp = b; vin = 1'b1;
      exp3.push_back(model({128'b0, w3}, 3, b));
      exp5.push_back(model(w5, 5, b));
   endtask

   task automatic clear_q;
      got3.delete(); got5.delete(); exp3.delete(); exp5.delete();
   endtask

   task automatic test_reset;
      rst = 1'b1; vin = 1'b0; rdy_in = 1'b1; byp = 1'b0; win3 = '0; win5 = '0;
      repeat (2) tick;
      rst = 1'b0;
      #1;
      vectors++; if (vout3 !== 1'b0) begin miscompares++; $display("FAIL reset_vout3 got %b want 0", vout3); end
      vectors++; if (dout3 !== 8'd0) begin miscompares++; $display("FAIL reset_dout3 got %0d want 0", dout3); end
      vectors++; if (err3 !== 1'b0) begin miscompares++; $display("FAIL reset_err3 got %b want 0", err3); end
      vectors++; if (busy3 !== 1'b0) begin miscompares++; $display("FAIL reset_busy3 got %b want 0", busy3); end
      vectors++; if (vout5 !== 1'b0 || busy5 !== 1'b0) begin miscompares++; $display("FAIL reset_dut5 got v=%b b=%b want 0 0", vout5, busy5); end
      rdy_in = 1'b0;
      #1;
      vectors++; if (ready3 !== 1'b1) begin miscompares++; $display("FAIL reset_ready3 got %b want 1", ready3); end
      rdy_in = 1'b1;
   endtask

   task automatic test_latency;
      clear_q();
      rand_load(100, 100, 100, 1'b0);
      for (int e = 1; e <= 3; e++) begin
         tick;
         vin = 1'b0;
         vectors++;
         if (vout3 !== (e == 3)) begin miscompares++; $display("FAIL latency_valid edge%0d got %b want %b", e, vout3, (e == 3)); end
      end
      vectors++; if (dout3 !== 8'd100) begin miscompares++; $display("FAIL latency_dout3 got %0d want 100", dout3); end
      vectors++; if (dout5 !== 8'd100) begin miscompares++; $display("FAIL latency_dout5 got %0d want 100", dout5); end
      repeat (3) tick;
   endtask

   task automatic test_rounding;
      clear_q();
      for (int p = 0; p < 10; p++) begin
         if (p == 0)      rand_load(0, 0, 255, 1'b0);
         else if (p == 1) rand_load(255, 255, 255, 1'b0);
         else             rand_load(0, 255, -1, 1'b0);
         tick;
      end
      vin = 1'b0;
      repeat (5) tick;
      vectors++; if (got3.size() != 10 || got5.size() != 10) begin miscompares++; $display("FAIL round_count got %0d/%0d want 10/10", got3.size(), got5.size()); end
      if (got3.size() >= 2 && got5.size() >= 2) begin
         vectors++; if (got3[0] != 64) begin miscompares++; $display("FAIL round_centre3 got %0d want 64", got3[0]); end
         vectors++; if (got5[0] != 36) begin miscompares++; $display("FAIL round_centre5 got %0d want 36", got5[0]); end
         vectors++; if (got3[1] != 255) begin miscompares++; $display("FAIL round_max3 got %0d want 255", got3[1]); end
         vectors++; if (got5[1] != 255) begin miscompares++; $display("FAIL round_max5 got %0d want 255", got5[1]); end
      end
      for (int i = 2; i < got3.size() && i < 10; i++) begin
         vectors++; if (got3[i] != exp3[i]) begin miscompares++; $display("FAIL round_rand3[%0d] got %0d want %0d", i, got3[i], exp3[i]); end
      end
      for (int i = 2; i < got5.size() && i < 10; i++) begin
         vectors++; if (got5[i] != exp5[i]) begin miscompares++; $display("FAIL round_rand5[%0d] got %0d want %0d", i, got5[i], exp5[i]); end
      end
   endtask

   task automatic test_stall;
      int idx = 0;
      logic [W-1:0] frozen3 = '0;
      logic [W-1:0] frozen5 = '0;
      clear_q();
      for (int cyc = 0; cyc < 16; cyc++) begin
         rdy_in = !(cyc >= 4 && cyc <= 7);
         if (rdy_in && idx < 6) begin
            rand_load(0, 255, -1, 1'b0);
            idx++;
         end else begin
            vin = 1'b0;
         end
         #1;
         if (!rdy_in) begin
            vectors++; if (ready3 !== 1'b0 || ready5 !== 1'b0) begin miscompares++; $display("FAIL stall_ready cyc%0d got %b/%b want 0/0", cyc, ready3, ready5); end
            if (cyc == 4) begin
               frozen3 = dout3; frozen5 = dout5;
            end else begin
               vectors++; if (vout3 !== 1'b1 || dout3 !== frozen3) begin miscompares++; $display("FAIL stall_frozen3 cyc%0d got v=%b d=%0d want v=1 d=%0d", cyc, vout3, dout3, frozen3); end
               vectors++; if (dout5 !== frozen5) begin miscompares++; $display("FAIL stall_frozen5 cyc%0d got %0d want %0d", cyc, dout5, frozen5); end
            end
         end
         tick;
      end
      vin = 1'b0; rdy_in = 1'b1;
      repeat (2) tick;
      vectors++; if (got3.size() != 6 || got5.size() != 6) begin miscompares++; $display("FAIL stall_count got %0d/%0d want 6/6", got3.size(), got5.size()); end
      for (int i = 0; i < got3.size() && i < 6; i++) begin
         vectors++; if (got3[i] != exp3[i]) begin miscompares++; $display("FAIL stall_order3[%0d] got %0d want %0d", i, got3[i], exp3[i]); end
      end
      for (int i = 0; i < got5.size() && i < 6; i++) begin
         vectors++; if (got5[i] != exp5[i]) begin miscompares++; $display("FAIL stall_order5[%0d] got %0d want %0d", i, got5[i], exp5[i]); end
      end
      vectors++; if (err3 !== 1'b0) begin miscompares++; $display("FAIL stall_noerr got %b want 0", err3); end
   endtask

   task automatic test_error;
      clear_q();
      for (int cyc = 0; cyc < 14; cyc++) begin
         rdy_in = !(cyc >= 3 && cyc <= 5);
         vin = 1'b0;
         if (cyc < 3 || cyc == 6 || cyc == 7) rand_load(0, 255, -1, 1'b0);
         if (cyc == 4) begin
            rand_load(0, 255, -1, 1'b0);
            void'(exp3.pop_back());
            void'(exp5.pop_back());
            #1;
            vectors++; if (err3 !== 1'b0) begin miscompares++; $display("FAIL err_early got %b want 0", err3); end
         end
         if (cyc == 5) begin
            vectors++; if (err3 !== 1'b1 || err5 !== 1'b1) begin miscompares++; $display("FAIL err_set got %b/%b want 1/1", err3, err5); end
         end
         tick;
      end
      vectors++; if (err3 !== 1'b1 || err5 !== 1'b1) begin miscompares++; $display("FAIL err_sticky got %b/%b want 1/1", err3, err5); end
      vectors++; if (got3.size() != 5 || got5.size() != 5) begin miscompares++; $display("FAIL err_count got %0d/%0d want 5/5", got3.size(), got5.size()); end
      for (int i = 0; i < got3.size() && i < 5; i++) begin
         vectors++; if (got3[i] != exp3[i]) begin miscompares++; $display("FAIL err_data3[%0d] got %0d want %0d", i, got3[i], exp3[i]); end
      end
      rst = 1'b1;
      tick;
      rst = 1'b0;
      vectors++; if (err3 !== 1'b0 || err5 !== 1'b0) begin miscompares++; $display("FAIL err_clear got %b/%b want 0/0", err3, err5); end
   endtask

   task automatic test_bypass;
      int unsigned centre [6];
      clear_q();
      rdy_in = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (c >= 3 && c <= 8) begin
            vectors++; if (vout3 !== 1'b1 || dout3 !== exp3[c-3]) begin miscompares++; $display("FAIL byp_out3[%0d] got v=%b d=%0d want v=1 d=%0d", c-3, vout3, dout3, exp3[c-3]); end
            vectors++; if (vout5 !== 1'b1 || dout5 !== exp5[c-3]) begin miscompares++; $display("FAIL byp_out5[%0d] got v=%b d=%0d want v=1 d=%0d", c-3, vout5, dout5, exp5[c-3]); end
            if ((c - 3) % 2 == 0) begin
               vectors++; if (dout3 !== centre[c-3]) begin miscompares++; $display("FAIL byp_centre[%0d] got %0d want %0d", c-3, dout3, centre[c-3]); end
            end
         end else begin
            vectors++; if (vout3 !== 1'b0) begin miscompares++; $display("FAIL byp_idle cyc%0d got %b want 0", c, vout3); end
         end
         if (c < 6) begin
            centre[c] = 10 * (c + 1);
            rand_load(100, 255, 10 * (c + 1), (c % 2) == 0);
         end else begin
            vin = 1'b0; byp = 1'b0;
         end
         tick;
      end
      repeat (2) tick;
   endtask

   task automatic test_reset_flush;
      clear_q();
      rdy_in = 1'b1;
      for (int c = 0; c < 3; c++) begin
         rand_load(0, 255, -1, 1'b0);
         tick;
      end
      rst = 1'b1; rdy_in = 1'b0;
      rand_load(0, 255, -1, 1'b0);
      tick;
      rst = 1'b0; vin = 1'b0; rdy_in = 1'b1;
      #1;
      vectors++; if (vout3 !== 1'b0 || vout5 !== 1'b0) begin miscompares++; $display("FAIL flush_valid got %b/%b want 0/0", vout3, vout5); end
      vectors++; if (busy3 !== 1'b0 || busy5 !== 1'b0) begin miscompares++; $display("FAIL flush_busy got %b/%b want 0/0", busy3, busy5); end
      vectors++; if (err3 !== 1'b0) begin miscompares++; $display("FAIL flush_err got %b want 0", err3); end
      vectors++; if (ready3 !== 1'b1) begin miscompares++; $display("FAIL flush_ready got %b want 1", ready3); end
      for (int c = 0; c < 6; c++) begin
         tick;
         vectors++; if (vout3 !== 1'b0 || vout5 !== 1'b0) begin miscompares++; $display("FAIL flush_stale cyc%0d got %b/%b want 0/0", c, vout3, vout5); end
      end
      vectors++; if (got3.size() != 0) begin miscompares++; $display("FAIL flush_none got %0d want 0", got3.size()); end
   endtask

   initial begin
      rst = 1'b1; vin = 1'b0; rdy_in = 1'b1; byp = 1'b0; win3 = '0; win5 = '0;
      @(negedge clk);
      test_reset();
      test_latency();
      test_rounding();
      test_stall();
      test_error();
      test_bypass();
      test_reset_flush();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/gaussian_conv.md
Name: gaussian_conv

Overview:
- Parametrised successor to the fixed 3x3 Gaussian blur: binomial Gaussian over a KSIZE x KSIZE window, KSIZE 3 or 5.
- Adds round-to-nearest, a per-sample bypass mode, valid/ready backpressure with pipeline stall, and a sticky overflow error.
- Sits between the line-buffer window generator and the octave/DoG stages of the SIFT pyramid.

Parameters:
- WIDTH, 8, pixel bit width (unsigned).
- KSIZE, 3, window size. Only 3 or 5 are legal; any other value is a elaboration-time error.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous reset, active high.
- window_in  input  KSIZE*KSIZE*WIDTH  window pixels. Pixel (r,c) is at [(r*KSIZE+c)*WIDTH +: WIDTH]; row 0 is top, col 0 is left.
- bypass_in  input  1  sampled with window_in. 1 = output the centre pixel unfiltered.
- data_valid_in  input  1  window_in is valid this cycle.
- data_ready_out  output  1  block accepts input this cycle.
- data_out  output  WIDTH  filtered (or bypassed) pixel.
- data_valid_out  output  1  data_out is valid.
- data_ready_in  input  1  downstream accepts data_out.
- error_out  output  1  sticky: an input was dropped.
- busy_out  output  1  any pipeline stage holds valid data.

Behaviour:
- Kernel:
  - KSIZE=3: outer product of [1 2 1], weights sum to 16, SHIFT=4.
  - KSIZE=5: outer product of [1 4 6 4 1], weights sum to 256, SHIFT=8.
  - Coefficients are constants, not registers.
- Pipeline: three registered stages S1, S2, S3, each with its own valid bit. Bypass flag and centre pixel travel alongside the data.
  - S1: per-column vertical weighted sum. Width WIDTH+SHIFT/2 bits.
  - S2: horizontal weighted sum of the column sums. Width WIDTH+SHIFT bits.
  - S3: (sum + 2^(SHIFT-1)) >> SHIFT. The maximum result is exactly 2^WIDTH-1, so saturation is never needed. S3 drives data_out.
  - If bypass is set, S3 loads the centre pixel (r=c=KSIZE/2) instead.
- All arithmetic is unsigned. No truncation anywhere before the final shift.
- Advance condition: advance = !S3.valid | data_ready_in.
  - When advance=1, all stages shift by one. When advance=0, every stage holds.
  - A valid-only bubble stage is not compressed; the pipeline is a simple global stall.
- data_ready_out = advance (combinational from data_ready_in).
- Latency: with no stall, data_valid_out rises 3 cycles after the accepting clock edge. Throughput is 1 sample/cycle.
- data_out and data_valid_out stay stable while data_valid_out=1 and data_ready_in=0.
- Error: data_valid_in=1 while data_ready_out=0 sets error_out=1.
  - The sample is dropped; pipeline contents are unaffected.
  - error_out clears only on reset.
- busy_out = S1.valid | S2.valid | S3.valid.
- Reset values: data_out=0, data_valid_out=0, error_out=0, busy_out=0, all stage valids=0.
- Reset mid-operation discards all in-flight samples. data_ready_out is 1 in the cycle after reset deasserts.
- Simultaneous events:
  - Input accepted while S3 drains: both happen in the same edge.
  - Reset asserted together with data_valid_in: the reset wins and the sample is dropped without setting error_out.

Decomposition:
- Package gaussian_pkg: binomial coefficient rows for sizes 3 and 5, function shift_for(KSIZE), centre-index constant.
- One natural sub-module, gaussian_col_sum: combinational KSIZE-tap vertical weighted sum. It is instantiated KSIZE times, with S1 registering their outputs.

Test Plan:
- KSIZE=3, all pixels 100, data_ready_in=1 -> data_out=100 exactly 3 cycles after accept.
- KSIZE=3, centre=255, others 0 -> 255*4/16=63.75 rounds to data_out=64. Repeat with KSIZE=5: 255*36/256=35.86 -> 36. Then all pixels 255 -> 255 for both sizes, confirming no overflow.
- Stream 6 distinct windows, hold data_ready_in=0 for cycles 4-7 -> data_ready_out=0 on those cycles, data_out frozen, no sample lost or duplicated, order preserved.
- Drive data_valid_in=1 during that stall -> error_out=1 from the next cycle. It persists through later traffic and clears only after rst_in.
- Alternate bypass_in=1/0 on a ramp of centre pixels 10,20,30 with blur-nonequivalent neighbours -> odd samples equal the centre pixel, even samples equal the filtered value, all at the same 3-cycle latency.
- Assert rst_in for 1 cycle with 3 samples in flight -> data_valid_out=0 and busy_out=0 the next cycle, and no stale sample ever emerges.
